// File: rtl/lfsr_gen_pkg.sv
// Shared types and the seven-segment glyph table for the LFSR demo block.
package lfsr_gen_pkg;

  typedef enum logic {
    MODE_RUN  = 1'b0,
    MODE_STEP = 1'b1
  } lfsr_mode_e;

  localparam int SEG_W = 7;

  // Active-high glyphs, bit order {g,f,e,d,c,b,a}.
  function automatic logic [SEG_W-1:0] seg_glyph(input logic [3:0] nib);
    logic [SEG_W-1:0] g;
    g = '0;
    case (nib)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/bcd7seg.sv
// Hex nibble to seven-segment decoder; segments are active-low to suit the board HEX displays.
module bcd7seg
  import lfsr_gen_pkg::*;
(
  input  logic [3:0]       bcd_i,
  output logic [SEG_W-1:0] seg_o
);

  assign seg_o = ~seg_glyph(bcd_i);

endmodule

// File: rtl/lfsr_gen_core.sv
// Fibonacci LFSR state register: right shift with the tap parity entering the MSB.
module lfsr_gen_core #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'h1D,
  parameter logic [WIDTH-1:0] SEED  = 8'h01
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] ld_val_i,
  input  logic             adv_i,
  output logic [WIDTH-1:0] state_o,
  output logic [WIDTH-1:0] next_o
);

  logic [WIDTH-1:0] state_q, state_d;
  logic             fb;

  assign fb      = ^(state_q & TAPS);
  assign next_o  = {fb, state_q[WIDTH-1:1]};
  assign state_o = state_q;

  always_comb begin
    state_d = state_q;
    if (ld_i) begin
      state_d = ld_val_i;
    end else if (adv_i) begin
      state_d = next_o;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/lfsr_gen.sv
// LFSR generator top: advance qualification, seed/lock-up handling, period measurement
// and one seven-segment digit per state nibble.
module lfsr_gen
  import lfsr_gen_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'h1D,
  parameter logic [WIDTH-1:0] SEED  = 8'h01,
  parameter int               NDIG  = (WIDTH + 3) / 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  step,
  input  logic                  load,
  input  logic [WIDTH-1:0]      seed_in,
  output logic [WIDTH-1:0]      state,
  output logic                  wrap,
  output logic [WIDTH-1:0]      period,
  output logic                  lockup,
  output logic [SEG_W*NDIG-1:0] hex
);

  logic [WIDTH-1:0] seed_q, seed_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic             wrap_q, wrap_d;
  logic             lockup_q, lockup_d;
  logic             step_q;

  logic [WIDTH-1:0] next_state;
  logic             adv_req;
  logic             lock_hit;
  logic             core_ld;
  logic [WIDTH-1:0] core_ld_val;
  logic             core_adv;

  assign adv_req  = (lfsr_mode_e'(mode) == MODE_STEP) ? (step & ~step_q) : en;
  // The all-zero state is only reachable through a load; a same-cycle load still wins.
  assign lock_hit = (state == '0) && !load;

  assign core_ld     = load | lock_hit;
  assign core_ld_val = load ? seed_in : SEED;
  assign core_adv    = adv_req & ~core_ld;

  lfsr_gen_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .ld_i     (core_ld),
    .ld_val_i (core_ld_val),
    .adv_i    (core_adv),
    .state_o  (state),
    .next_o   (next_state)
  );

  always_comb begin
    seed_d   = seed_q;
    count_d  = count_q;
    period_d = period_q;
    wrap_d   = 1'b0;
    lockup_d = 1'b0;
    if (load) begin
      seed_d  = seed_in;
      count_d = '0;
    end else if (lock_hit) begin
      seed_d   = SEED;
      count_d  = '0;
      lockup_d = 1'b1;
    end else if (adv_req) begin
      count_d = count_q + 1'b1;
      if (next_state == seed_q) begin
        wrap_d   = 1'b1;
        period_d = count_q + 1'b1;
        count_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seed_q   <= SEED;
      count_q  <= '0;
      period_q <= '0;
      wrap_q   <= 1'b0;
      lockup_q <= 1'b0;
      step_q   <= 1'b0;
    end else begin
      seed_q   <= seed_d;
      count_q  <= count_d;
      period_q <= period_d;
      wrap_q   <= wrap_d;
      lockup_q <= lockup_d;
      step_q   <= step;
    end
  end

  assign wrap   = wrap_q;
  assign lockup = lockup_q;
  assign period = period_q;

  // Zero-pad the state so the top digit shows a partial nibble cleanly.
  logic [4*NDIG-1:0] state_pad;
  assign state_pad = (4 * NDIG)'(state);

  for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
    bcd7seg u_seg (
      .bcd_i (state_pad[4*gi +: 4]),
      .seg_o (hex[SEG_W*gi +: SEG_W])
    );
  end

endmodule

// File: tb/tb_lfsr_gen.sv
// Self-checking bench for lfsr_gen: directed scenarios plus randomized traffic against a
// behavioural model, and a 16-bit instance run through its full period.
module tb_lfsr_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en, mode, step, load;
  logic [7:0]  seed_in, state8, period8;
  logic        wrap8, lockup8;
  logic [13:0] hex8;

  logic        en16, mode16, step16, load16;
  logic [15:0] seed16, state16, period16;
  logic        wrap16, lockup16;
  logic [27:0] hex16;

  lfsr_gen dut8 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .step(step), .load(load),
    .seed_in(seed_in), .state(state8), .wrap(wrap8), .period(period8),
    .lockup(lockup8), .hex(hex8)
  );

  // 0xB400 in the usual left-shift tap notation; with feedback entering the MSB
  // the same primitive polynomial x^16+x^14+x^13+x^11+1 is the mask 0x6801.
  lfsr_gen #(.WIDTH(16), .TAPS(16'h6801), .SEED(16'h0001)) dut16 (
    .clk(clk), .rst_n(rst_n), .en(en16), .mode(mode16), .step(step16), .load(load16),
    .seed_in(seed16), .state(state16), .wrap(wrap16), .period(period16),
    .lockup(lockup16), .hex(hex16)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference glyphs (active-low, {g..a}) for each hex value.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] tbl [16];
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return ~tbl[n];
  endfunction

  // Behavioural model of the 8-bit instance.
  logic [7:0] m_state, m_seed, m_count, m_period;
  logic       m_wrap, m_lock, m_stepq;

  task automatic model_reset();
    m_state = 8'h01; m_seed = 8'h01; m_count = 8'h00; m_period = 8'h00;
    m_wrap = 1'b0; m_lock = 1'b0; m_stepq = 1'b0;
  endtask

  task automatic model_edge();
    logic       go;
    int         par;
    logic [7:0] nxt;
    go     = mode ? (step && !m_stepq) : en;
    m_wrap = 1'b0;
    m_lock = 1'b0;
    if (load) begin
      m_state = seed_in; m_seed = seed_in; m_count = 0;
    end else if (m_state == 0) begin
      m_state = 8'h01; m_seed = 8'h01; m_count = 0; m_lock = 1'b1;
    end else if (go) begin
      par     = $countones(m_state & 8'h1D) % 2;
      nxt     = (m_state >> 1) + ((par == 1) ? 8'h80 : 8'h00);
      m_state = nxt;
      m_count = m_count + 1;
      if (nxt == m_seed) begin
        m_wrap = 1'b1; m_period = m_count; m_count = 0;
      end
    end
    m_stepq = step;
  endtask

  task automatic check_all(input string ph);
    check({ph, "_state"},  state8,  m_state);
    check({ph, "_wrap"},   wrap8,   m_wrap);
    check({ph, "_lockup"}, lockup8, m_lock);
    check({ph, "_period"}, period8, m_period);
    check({ph, "_hex"},    hex8,    {seg7(m_state[7:4]), seg7(m_state[3:0])});
  endtask

  task automatic tick(input string ph);
    model_edge();
    @(posedge clk);
    #1;
    check_all(ph);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] seq1 [5];
    int         wraps;
    int         wraps16;
    seq1 = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h88};

    rst_n = 1'b0; en = 0; mode = 0; step = 0; load = 0; seed_in = 0;
    en16 = 0; mode16 = 0; step16 = 0; load16 = 0; seed16 = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    check("reset16_state", state16, 32'h0001);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: first five free-run advances
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick("t1");
      check("t1_seq", state8, seq1[i]);
      check("t1_hex0", hex8[6:0], seg7(seq1[i][3:0]));
    end
    $display("phase 1 done: state=0x%0h", state8);

    // 2: full period twice
    apply_reset();
    en = 1'b1; wraps = 0;
    for (int i = 0; i < 255; i++) begin
      tick("t2");
      if (wrap8) wraps++;
    end
    check("t2_wraps1", wraps, 1);
    check("t2_period1", period8, 255);
    check("t2_state1", state8, 8'h01);
    for (int i = 0; i < 255; i++) begin
      tick("t2b");
      if (wrap8) wraps++;
    end
    check("t2_wraps2", wraps, 2);
    check("t2_period2", period8, 255);
    $display("phase 2 done: period=%0d wraps=%0d", period8, wraps);

    // 3: single-step on rising step edges only
    apply_reset();
    mode = 1'b1; en = 1'b1; step = 1'b1;
    repeat (10) tick("t3");
    check("t3_first", state8, 8'h80);
    step = 1'b0;
    repeat (3) tick("t3");
    check("t3_hold", state8, 8'h80);
    step = 1'b1;
    repeat (3) tick("t3");
    check("t3_second", state8, 8'h40);
    $display("phase 3 done: state=0x%0h", state8);

    // 4: runtime seed load overrides advance
    apply_reset();
    mode = 1'b0; step = 1'b0; en = 1'b1;
    repeat (7) tick("t4");
    load = 1'b1; seed_in = 8'h5A;
    tick("t4");
    check("t4_loaded", state8, 8'h5A);
    load = 1'b0; wraps = 0;
    for (int i = 0; i < 255; i++) begin
      tick("t4");
      if (wrap8) wraps++;
    end
    check("t4_wraps", wraps, 1);
    check("t4_period", period8, 255);
    check("t4_state", state8, 8'h5A);
    $display("phase 4 done: period=%0d", period8);

    // 5: all-zero lock-up recovery
    load = 1'b1; seed_in = 8'h00;
    tick("t5");
    check("t5_zero", state8, 8'h00);
    load = 1'b0;
    tick("t5");
    check("t5_recover", state8, 8'h01);
    check("t5_lockpulse", lockup8, 1'b1);
    tick("t5");
    check("t5_lockclr", lockup8, 1'b0);
    check("t5_resume", state8, 8'h80);
    $display("phase 5 done: state=0x%0h", state8);

    // 6: asynchronous reset mid-run
    apply_reset();
    en = 1'b1;
    repeat (260) tick("t6");
    check("t6_pre_state", state8, 8'h88);
    check("t6_pre_period", period8, 255);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_async_state", state8, 8'h01);
    check("t6_async_period", period8, 8'h00);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    $display("phase 6 done");

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      en      = 1'($urandom_range(0, 1));
      mode    = ($urandom_range(0, 3) == 0);
      step    = 1'($urandom_range(0, 1));
      load    = ($urandom_range(0, 31) == 0);
      seed_in = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      tick("rnd");
    end
    en = 0; mode = 0; step = 0; load = 0;
    $display("random phase done: checks=%0d", checks);

    // 16-bit instance: full maximal period
    en16 = 1'b1;
    @(posedge clk);
    #1;
    check("w16_first", state16, 32'h8000);
    check("w16_hex_first", hex16, {seg7(4'h8), seg7(4'h0), seg7(4'h0), seg7(4'h0)});
    wraps16 = 0;
    for (int i = 1; i < 65535; i++) begin
      @(posedge clk);
      #1;
      if (wrap16) wraps16++;
    end
    en16 = 1'b0;
    check("w16_wraps", wraps16, 1);
    check("w16_period", period16, 32'hFFFF);
    check("w16_state", state16, 32'h0001);
    check("w16_hex", hex16, {seg7(4'h0), seg7(4'h0), seg7(4'h0), seg7(4'h1)});
    check("w16_lockup", lockup16, 1'b0);
    $display("16-bit phase done: period=%0d", period16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
